// File: rtl/rpsc_pkg.sv
// Shared types and default timing constants for the HV turn-on/turn-off sequencer.
package rpsc_pkg;

  // Defaults in interlock-clock cycles (64 cycles per second).
  localparam int unsigned G1_TIMEOUT_DEF = 192;
  localparam int unsigned AN_TIMEOUT_DEF = 384;
  localparam int unsigned OFF_DELAY_DEF  = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_G1_RAMP  = 3'd1,
    ST_AN_RAMP  = 3'd2,
    ST_RUN      = 3'd3,
    ST_SHUTDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_G1_TIMEOUT = 2'b01,
    FC_AN_TIMEOUT = 2'b10,
    FC_INTERLOCK  = 2'b11
  } fault_code_t;

  // Largest of three limits; sizes the shared stage timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rpsc_timer.sv
// Saturating stage timer: cleared on state entry, flags the edge at which the
// stage has lasted limit_i cycles.
module rpsc_timer #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expire_c_o
);

  localparam int unsigned WE = W + 1;

  logic [W-1:0]  count_q, count_d;
  logic [WE-1:0] count_next_ext;

  // Next count: clear wins, otherwise count up and hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds k-1 at the k-th edge after entry, so expiry fires at edge limit_i.
  assign count_next_ext = {1'b0, count_q} + WE'(1);
  assign expire_c_o     = (count_next_ext >= {1'b0, limit_i});

endmodule

// File: rtl/rpsc_hv_sequencer.sv
// Grid/anode supply sequencer with per-stage timeouts and a latched fault code.
module rpsc_hv_sequencer
  import rpsc_pkg::*;
#(
  parameter int unsigned G1_TIMEOUT = G1_TIMEOUT_DEF,
  parameter int unsigned AN_TIMEOUT = AN_TIMEOUT_DEF,
  parameter int unsigned OFF_DELAY  = OFF_DELAY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       fault_clr,
  input  logic       not_alarm,
  input  logic       not_g1_ok,
  input  logic       not_th_an_ready,
  input  logic       not_an_ok,
  output logic       g1_ps_act,
  output logic       an_ps_act,
  output logic       run_ok,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] seq_state
);

  localparam int unsigned TW = $clog2(max3(G1_TIMEOUT, AN_TIMEOUT, OFF_DELAY) + 1);

  seq_state_t  state_q, state_d;
  fault_code_t code_q, code_d;
  logic        g1_act_q, an_act_q, run_ok_q, fault_q;
  logic        tmr_clr_c, tmr_expire_c, drop_c;
  logic [TW-1:0] tmr_limit_c;

  // Stage limit for the state currently being timed.
  always_comb begin
    tmr_limit_c = '1;
    case (state_q)
      ST_G1_RAMP:  tmr_limit_c = TW'(G1_TIMEOUT);
      ST_AN_RAMP:  tmr_limit_c = TW'(AN_TIMEOUT);
      ST_SHUTDOWN: tmr_limit_c = TW'(OFF_DELAY);
      default:     tmr_limit_c = '1;
    endcase
  end

  assign tmr_clr_c = (state_d != state_q);

  rpsc_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (tmr_clr_c),
    .en_i       (1'b1),
    .limit_i    (tmr_limit_c),
    .expire_c_o (tmr_expire_c)
  );

  // Interlock drop: which card 2 signals must stay healthy depends on how far the ramp got.
  always_comb begin
    drop_c = 1'b0;
    case (state_q)
      ST_G1_RAMP: drop_c = !not_alarm;
      ST_AN_RAMP: drop_c = !not_alarm || not_g1_ok || not_th_an_ready;
      ST_RUN:     drop_c = !not_alarm || not_g1_ok || not_th_an_ready || not_an_ok;
      default:    drop_c = 1'b0;
    endcase
  end

  // Next state and fault code; priority is drop, success, timeout, stop, start.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req && not_alarm && !fault_q) state_d = ST_G1_RAMP;
      end
      ST_G1_RAMP: begin
        if (drop_c) begin
          state_d = ST_FAULT;
          code_d  = FC_INTERLOCK;
        end else if (!not_g1_ok) begin
          if (not_th_an_ready) begin
            state_d = ST_FAULT;
            code_d  = FC_INTERLOCK;
          end else begin
            state_d = ST_AN_RAMP;
          end
        end else if (tmr_expire_c) begin
          state_d = ST_FAULT;
          code_d  = FC_G1_TIMEOUT;
        end else if (stop_req) begin
          state_d = ST_SHUTDOWN;
        end
      end
      ST_AN_RAMP: begin
        if (drop_c) begin
          state_d = ST_FAULT;
          code_d  = FC_INTERLOCK;
        end else if (!not_an_ok) begin
          state_d = ST_RUN;
        end else if (tmr_expire_c) begin
          state_d = ST_FAULT;
          code_d  = FC_AN_TIMEOUT;
        end else if (stop_req) begin
          state_d = ST_SHUTDOWN;
        end
      end
      ST_RUN: begin
        if (drop_c) begin
          state_d = ST_FAULT;
          code_d  = FC_INTERLOCK;
        end else if (stop_req) begin
          state_d = ST_SHUTDOWN;
        end
      end
      ST_SHUTDOWN: begin
        if (tmr_expire_c) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr && not_alarm) begin
          state_d = ST_IDLE;
          code_d  = FC_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = FC_NONE;
      end
    endcase
  end

  // State and registered outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      code_q   <= FC_NONE;
      g1_act_q <= 1'b0;
      an_act_q <= 1'b0;
      run_ok_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      g1_act_q <= (state_d == ST_G1_RAMP) || (state_d == ST_AN_RAMP) ||
                  (state_d == ST_RUN)     || (state_d == ST_SHUTDOWN);
      an_act_q <= (state_d == ST_AN_RAMP) || (state_d == ST_RUN);
      run_ok_q <= (state_d == ST_RUN);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign g1_ps_act  = g1_act_q;
  assign an_ps_act  = an_act_q;
  assign run_ok     = run_ok_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// Bench for rpsc_hv_sequencer: directed scenarios plus random input activity,
// checked every cycle against a phase/age model of the sequencing rules.
module tb_rpsc_hv_sequencer;
  import rpsc_pkg::*;

  localparam int G1_TO  = 192;
  localparam int AN_TO  = 384;
  localparam int OFF_DL = 64;

  logic       clk, reset;
  logic       start_req, stop_req, fault_clr;
  logic       not_alarm, not_g1_ok, not_th_an_ready, not_an_ok;
  logic       g1_ps_act, an_ps_act, run_ok, fault;
  logic [1:0] fault_code;
  logic [2:0] seq_state;

  int n_checks = 0;
  int n_pass   = 0;

  rpsc_hv_sequencer #(
    .G1_TIMEOUT (G1_TO),
    .AN_TIMEOUT (AN_TO),
    .OFF_DELAY  (OFF_DL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_req       (start_req),
    .stop_req        (stop_req),
    .fault_clr       (fault_clr),
    .not_alarm       (not_alarm),
    .not_g1_ok       (not_g1_ok),
    .not_th_an_ready (not_th_an_ready),
    .not_an_ok       (not_an_ok),
    .g1_ps_act       (g1_ps_act),
    .an_ps_act       (an_ps_act),
    .run_ok          (run_ok),
    .fault           (fault),
    .fault_code      (fault_code),
    .seq_state       (seq_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: current phase, edges spent in it, and the latched fault code.
  seq_state_t  m_ph   = ST_IDLE;
  int          m_age  = 0;
  fault_code_t m_code = FC_NONE;

  task automatic model_step();
    seq_state_t  nxt;
    fault_code_t why;
    bit          active, drop, ok_seen;
    if (!reset) begin
      m_ph = ST_IDLE; m_age = 0; m_code = FC_NONE;
      return;
    end
    m_age++;
    nxt     = m_ph;
    why     = FC_INTERLOCK;
    active  = (m_ph == ST_G1_RAMP) || (m_ph == ST_AN_RAMP) || (m_ph == ST_RUN);
    drop    = active && !not_alarm;
    if ((m_ph == ST_AN_RAMP) || (m_ph == ST_RUN)) drop = drop || not_g1_ok || not_th_an_ready;
    if (m_ph == ST_RUN) drop = drop || not_an_ok;
    ok_seen = ((m_ph == ST_G1_RAMP) && !not_g1_ok) || ((m_ph == ST_AN_RAMP) && !not_an_ok);
    if (drop) nxt = ST_FAULT;
    else if (ok_seen) begin
      if (m_ph == ST_AN_RAMP) nxt = ST_RUN;
      else if (not_th_an_ready) nxt = ST_FAULT;
      else nxt = ST_AN_RAMP;
    end else if ((m_ph == ST_G1_RAMP) && (m_age >= G1_TO)) begin
      nxt = ST_FAULT; why = FC_G1_TIMEOUT;
    end else if ((m_ph == ST_AN_RAMP) && (m_age >= AN_TO)) begin
      nxt = ST_FAULT; why = FC_AN_TIMEOUT;
    end else if (active && stop_req) nxt = ST_SHUTDOWN;
    else if ((m_ph == ST_IDLE) && start_req && not_alarm) nxt = ST_G1_RAMP;
    else if ((m_ph == ST_SHUTDOWN) && (m_age >= OFF_DL)) nxt = ST_IDLE;
    else if ((m_ph == ST_FAULT) && fault_clr && not_alarm) begin
      nxt = ST_IDLE; m_code = FC_NONE;
    end
    if ((nxt == ST_FAULT) && (m_ph != ST_FAULT)) m_code = why;
    if (nxt != m_ph) m_age = 0;
    m_ph = nxt;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    logic [8:0] exp_v, act_v;
    logic       e_g1, e_an;
    model_step();
    #1;
    e_g1  = (m_ph == ST_G1_RAMP) || (m_ph == ST_AN_RAMP) || (m_ph == ST_RUN) ||
            (m_ph == ST_SHUTDOWN);
    e_an  = (m_ph == ST_AN_RAMP) || (m_ph == ST_RUN);
    exp_v = {e_g1, e_an, (m_ph == ST_RUN), (m_ph == ST_FAULT), m_code, m_ph};
    act_v = {g1_ps_act, an_ps_act, run_ok, fault, fault_code, seq_state};
    chk("cycle_outputs", int'(act_v), int'(exp_v));
  end

  task automatic idle_inputs();
    start_req = 0; stop_req = 0; fault_clr = 0;
    not_alarm = 1; not_g1_ok = 1; not_th_an_ready = 0; not_an_ok = 1;
  endtask

  // From IDLE at a negedge: start, G1 OK d1 cycles later, anode OK d2 cycles after that.
  task automatic bring_up(input int d1, input int d2);
    start_req = 1;
    @(posedge clk); #1;
    chk("g1_after_start", int'(g1_ps_act), 1);
    chk("an_off_in_g1_ramp", int'(an_ps_act), 0);
    @(negedge clk); start_req = 0;
    repeat (d1 - 1) @(negedge clk);
    not_g1_ok = 0;
    @(posedge clk); #1;
    chk("an_after_g1_ok", int'(an_ps_act), 1);
    @(negedge clk);
    repeat (d2 - 1) @(negedge clk);
    not_an_ok = 0;
    @(posedge clk); #1;
    chk("run_ok_set", int'(run_ok), 1);
    chk("no_fault_in_run", int'(fault), 0);
    @(negedge clk);
  endtask

  task automatic clear_fault();
    idle_inputs();
    fault_clr = 1;
    @(posedge clk); #1;
    chk("clear_code", int'(fault_code), 0);
    chk("clear_state_idle", int'(seq_state), int'(ST_IDLE));
    @(negedge clk); fault_clr = 0;
  endtask

  // Edges until fault rises, bounded.
  task automatic edges_to_fault(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!fault && n < 1000);
  endtask

  initial begin
    int n;
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({g1_ps_act, an_ps_act, run_ok, fault, fault_code, seq_state}), 0);
    reset = 1;
    repeat (3) @(negedge clk);

    // Normal start then stop.
    bring_up(10, 20);
    repeat (5) @(negedge clk);
    stop_req = 1;
    @(posedge clk); #1;
    chk("stop_an_off", int'(an_ps_act), 0);
    chk("stop_g1_held", int'(g1_ps_act), 1);
    @(negedge clk);
    stop_req = 0; not_g1_ok = 1; not_an_ok = 1;
    repeat (OFF_DL - 1) @(posedge clk);
    #1 chk("g1_held_last_shutdown_cycle", int'(g1_ps_act), 1);
    @(posedge clk); #1;
    chk("g1_off_after_delay", int'(g1_ps_act), 0);
    chk("idle_after_shutdown", int'(seq_state), int'(ST_IDLE));
    @(negedge clk);

    // G1 timeout.
    start_req = 1;
    @(posedge clk); #1;
    @(negedge clk); start_req = 0;
    edges_to_fault(n);
    chk("g1_timeout_cycles", n, 192);
    chk("g1_timeout_code", int'(fault_code), 1);
    chk("g1_timeout_acts", int'({g1_ps_act, an_ps_act}), 0);
    @(negedge clk);
    clear_fault();

    // G1 OK exactly at the timeout edge wins, then anode timeout.
    start_req = 1;
    @(posedge clk); #1;
    @(negedge clk); start_req = 0;
    repeat (G1_TO - 1) @(negedge clk);
    not_g1_ok = 0;
    @(posedge clk); #1;
    chk("g1_boundary_an_ramp", int'(an_ps_act), 1);
    chk("g1_boundary_no_fault", int'(fault), 0);
    edges_to_fault(n);
    chk("an_timeout_cycles", n, 384);
    chk("an_timeout_code", int'(fault_code), 2);
    @(negedge clk);
    clear_fault();

    // Thermal/anode not ready when G1 OK arrives.
    not_th_an_ready = 1;
    start_req = 1;
    @(posedge clk); #1;
    @(negedge clk); start_req = 0;
    repeat ($urandom_range(5, 40)) @(negedge clk);
    not_g1_ok = 0;
    @(posedge clk); #1;
    chk("not_ready_fault", int'(fault), 1);
    chk("not_ready_code", int'(fault_code), 3);
    chk("not_ready_no_anode", int'(an_ps_act), 0);
    @(negedge clk);
    clear_fault();

    // Alarm pulse in RUN, then clear attempts.
    bring_up($urandom_range(1, 30), $urandom_range(1, 30));
    not_alarm = 0;
    @(posedge clk); #1;
    chk("alarm_fault", int'(fault), 1);
    chk("alarm_code", int'(fault_code), 3);
    chk("alarm_acts_off", int'({g1_ps_act, an_ps_act}), 0);
    @(negedge clk); not_alarm = 1;
    @(negedge clk); not_alarm = 0; fault_clr = 1;
    @(posedge clk); #1;
    chk("clr_ignored_in_alarm", int'(fault), 1);
    @(negedge clk); not_alarm = 1;
    @(posedge clk); #1;
    chk("clr_accepted", int'(fault), 0);
    chk("clr_code_none", int'(fault_code), 0);
    @(negedge clk);
    idle_inputs();

    // Reset asserted mid AN_RAMP.
    start_req = 1;
    @(negedge clk); start_req = 0;
    repeat (4) @(negedge clk);
    not_g1_ok = 0;
    repeat (3) @(negedge clk);
    chk("pre_reset_in_an_ramp", int'(an_ps_act), 1);
    #2 reset = 0;
    #1 chk("async_reset_outputs",
           int'({g1_ps_act, an_ps_act, run_ok, fault, fault_code, seq_state}), 0);
    idle_inputs();
    @(negedge clk); reset = 1;
    @(negedge clk);

    // Random activity.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(99) < 4) start_req = ~start_req;
      stop_req  = ($urandom_range(199) == 0);
      fault_clr = ($urandom_range(19) == 0);
      if ($urandom_range(299) == 0) not_alarm = 0;
      else if ($urandom_range(9) == 0) not_alarm = 1;
      if ($urandom_range(29) == 0) not_g1_ok = ~not_g1_ok;
      if ($urandom_range(29) == 0) not_an_ok = ~not_an_ok;
      if ($urandom_range(199) == 0) not_th_an_ready = ~not_th_an_ready;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rpsc_hv_sequencer.md
# rpsc_hv_sequencer

Turn-on/turn-off sequencer that drives the power-supply activate commands consumed by the card 2 interlock logic. It initiates the grid (G1) and anode supplies in order and monitors card 2 status feedback (alarm, G1 OK, thermal/anode ready, anode OK) with per-stage timeouts. It latches a coded fault on any timeout or interlock drop. It sits between the operator start/stop controls and card 2, on the same slow interlock clock (64 cycles per second).

## Interface
Parameters:
- G1_TIMEOUT, 192: cycles allowed in G1_RAMP for G1 OK (3 s).
- AN_TIMEOUT, 384: cycles allowed in AN_RAMP for anode OK (6 s).
- OFF_DELAY, 64: cycles between anode off and G1 off in SHUTDOWN (1 s).

Ports:
- clk  in  1  interlock clock; the only clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- start_req  in  1  operator start level.
- stop_req  in  1  operator stop level.
- fault_clr  in  1  operator fault acknowledge.
- not_alarm  in  1  card 2 G1 alarm status; 1 = no alarm.
- not_g1_ok  in  1  card 2 G1 status; 0 = G1 OK.
- not_th_an_ready  in  1  card 2 thermal/anode ready; 0 = ready.
- not_an_ok  in  1  card 2 anode status; 0 = anode OK.
- g1_ps_act  out  1  G1 supply activate.
- an_ps_act  out  1  anode supply activate.
- run_ok  out  1  sequence complete, both supplies good.
- fault  out  1  fault latched.
- fault_code  out  2  00 none, 01 G1 timeout, 10 anode timeout, 11 interlock drop.
- seq_state  out  3  current state encoding, for diagnostics.

## Operation
- States: IDLE, G1_RAMP, AN_RAMP, RUN, SHUTDOWN, FAULT.
- IDLE: both acts 0. If start_req=1, not_alarm=1 and fault=0, go to G1_RAMP and clear the timer.
- G1_RAMP: g1_ps_act=1. If not_g1_ok=0, go to AN_RAMP.
- AN_RAMP: g1_ps_act=1, an_ps_act=1. If not_an_ok=0, go to RUN.
- Entering AN_RAMP requires not_th_an_ready=0 on the same cycle. If it is not ready, go to FAULT with code 11.
- RUN: both acts 1, run_ok=1.
- Interlock drop, code 11. Causes:
  - not_alarm=0 in any active state (G1_RAMP, AN_RAMP, RUN).
  - not_g1_ok=1 in AN_RAMP or RUN.
  - not_th_an_ready=1 in AN_RAMP or RUN.
  - not_an_ok=1 in RUN.
- Timeouts: G1_RAMP timeout → FAULT, code 01. AN_RAMP timeout → FAULT, code 10.
- stop_req=1 in G1_RAMP, AN_RAMP or RUN → SHUTDOWN.
- SHUTDOWN: an_ps_act=0 and g1_ps_act=1 for OFF_DELAY cycles, then go to IDLE with g1_ps_act=0. Interlock checks are ignored in SHUTDOWN.
- FAULT: both acts 0, fault=1, fault_code held. If fault_clr=1 and not_alarm=1, go to IDLE and clear fault_code to 00.
- Priority on a single cycle, highest first: interlock drop, success (OK seen), timeout, stop_req, start_req.
- start_req is level-sensitive and only honoured in IDLE. A start_req held high restarts the sequence after SHUTDOWN.

## Timing
- All outputs are registered. A change appears one clock after the input is sampled.
- Reset values: state IDLE; g1_ps_act, an_ps_act, run_ok, fault = 0; fault_code = 00; seq_state = IDLE encoding; timer = 0.
- Timeout rule: enter the state at edge E0. If OK is not sampled at any of edges E1..E_TIMEOUT, transition to FAULT at edge E_TIMEOUT. OK sampled exactly at E_TIMEOUT wins over the timeout.
- SHUTDOWN lasts exactly OFF_DELAY cycles.
- Timer width is $clog2(max(G1_TIMEOUT, AN_TIMEOUT, OFF_DELAY)+1). The timer saturates and never wraps.
- Reset asserted mid-sequence drops both acts immediately (asynchronously) and discards any latched fault.

## Structure
- Package rpsc_pkg holds:
  - the seq_state_t enum (3-bit);
  - the fault_code_t enum;
  - the default timeout constants.
- Sub-module rpsc_timer: load/clear, count-enable and expire-at-limit, with a limit input. One instance is shared by all states and cleared on every state entry.
- The top level is one FSM plus the fault register.

## Test plan
- Normal start:
  - Stimulus: card 2 inputs healthy; start_req=1; not_g1_ok falls 10 cycles later; not_an_ok falls 20 cycles after that.
  - Response: g1_ps_act rises 1 cycle after start_req, an_ps_act rises 1 cycle after G1 OK, run_ok=1, fault=0.
- G1 timeout:
  - Stimulus: not_g1_ok held at 1.
  - Response: FAULT with fault_code=01 exactly 192 cycles after G1_RAMP entry; both acts 0.
  - Boundary: not_g1_ok falling at cycle 192 enters AN_RAMP instead.
- Anode timeout and readiness:
  - Stimulus: not_an_ok held at 1.
  - Response: fault_code=10 after 384 cycles.
  - Stimulus: not_th_an_ready=1 when G1 OK arrives.
  - Response: fault_code=11 and an_ps_act never asserts.
- Interlock drop in RUN:
  - Stimulus: not_alarm pulses to 0 for 1 cycle while in RUN.
  - Response: next cycle both acts 0, fault=1, code 11.
  - Stimulus: fault_clr while not_alarm=0.
  - Response: ignored; FAULT is held.
  - Stimulus: fault_clr with not_alarm=1.
  - Response: IDLE, code 00.
- Stop and reset:
  - Stimulus: stop_req in RUN.
  - Response: an_ps_act falls at once; g1_ps_act falls 64 cycles later; then IDLE.
  - Stimulus: reset asserted in the middle of AN_RAMP.
  - Response: acts 0 asynchronously; all outputs at reset values.
